// File: rtl/mesh_phase_sequencer.sv
// Broadcast phase/step sequencer for the PE sort mesh: walks every round through
// COMPUTE, PUSH_ADDR and GET_DATA sub-phases and drives the shared ROM address.
module mesh_phase_sequencer #(
  parameter int SQRT_N         = 32,
  parameter int SORT_CYCLES    = 222,
  parameter int COMPUTE_CYCLES = 3,
  parameter int CNT_WIDTH      = 10,
  parameter int ROUND_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ROUND_WIDTH-1:0] num_rounds,
  input  logic                   pause,
  input  logic                   abort,
  output logic [2:0]             phase,
  output logic [1:0]             step,
  output logic [CNT_WIDTH-1:0]   inst_addr,
  output logic                   mesh_en,
  output logic                   busy,
  output logic [ROUND_WIDTH-1:0] round_idx,
  output logic                   done
);

  // state    | meaning
  // IDLE     | waiting for start, mesh disabled
  // COMP     | local compute window
  // PA_SORT  | push address, sort pass (ROM driven)
  // PA_ROW   | push address, row alignment
  // PA_COL   | push address, column alignment
  // GD_SORT  | get data, sort pass (ROM driven)
  // GD_ROW   | get data, row alignment
  // GD_COL   | get data, column alignment; round ends here
  typedef enum logic [2:0] {
    S_IDLE, S_COMP, S_PA_SORT, S_PA_ROW, S_PA_COL, S_GD_SORT, S_GD_ROW, S_GD_COL
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LIM_COMP = CNT_WIDTH'(COMPUTE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LIM_SORT = CNT_WIDTH'(SORT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LIM_MESH = CNT_WIDTH'(SQRT_N);

  localparam logic [2:0] PH_SORT = 3'b000;
  localparam logic [2:0] PH_ROW  = 3'b001;
  localparam logic [2:0] PH_COL  = 3'b010;
  localparam logic [2:0] PH_NOP  = 3'b111;
  localparam logic [1:0] ST_PA   = 2'b00;
  localparam logic [1:0] ST_GD   = 2'b01;
  localparam logic [1:0] ST_COMP = 2'b10;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ROUND_WIDTH-1:0] round_q, round_d;
  logic [ROUND_WIDTH-1:0] rounds_q, rounds_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   mesh_en_q, mesh_en_d;
  logic [2:0]             phase_q, phase_d;
  logic [1:0]             step_q, step_d;

  logic [CNT_WIDTH-1:0]   limit;
  logic [ROUND_WIDTH:0]   round_inc;
  logic                   more_rounds;

  always_comb begin
    limit = '0;
    case (state_q)
      S_COMP:              limit = LIM_COMP;
      S_PA_SORT, S_GD_SORT: limit = LIM_SORT;
      S_PA_ROW, S_PA_COL,
      S_GD_ROW, S_GD_COL:  limit = LIM_MESH;
      default:             limit = '0;
    endcase
  end

  // Extra bit so round_idx+1 cannot overflow when num_rounds is at its maximum.
  assign round_inc   = {1'b0, round_q} + {{ROUND_WIDTH{1'b0}}, 1'b1};
  assign more_rounds = round_inc < {1'b0, rounds_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    round_d  = round_q;
    rounds_d = rounds_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (state_q == S_IDLE) begin
      if (start && !abort) begin
        rounds_d = (num_rounds == '0) ? ROUND_WIDTH'(1) : num_rounds;
        round_d  = '0;
        busy_d   = 1'b1;
        cnt_d    = '0;
        state_d  = S_COMP;
      end
    end else if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else if (!pause) begin
      if (cnt_q == limit) begin
        cnt_d = '0;
        case (state_q)
          S_COMP:    state_d = S_PA_SORT;
          S_PA_SORT: state_d = S_PA_ROW;
          S_PA_ROW:  state_d = S_PA_COL;
          S_PA_COL:  state_d = S_GD_SORT;
          S_GD_SORT: state_d = S_GD_ROW;
          S_GD_ROW:  state_d = S_GD_COL;
          S_GD_COL: begin
            if (more_rounds) begin
              round_d = round_inc[ROUND_WIDTH-1:0];
              state_d = S_COMP;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
          default:   state_d = S_IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    phase_d = PH_NOP;
    step_d  = ST_COMP;
    case (state_d)
      S_PA_SORT: begin phase_d = PH_SORT; step_d = ST_PA; end
      S_PA_ROW:  begin phase_d = PH_ROW;  step_d = ST_PA; end
      S_PA_COL:  begin phase_d = PH_COL;  step_d = ST_PA; end
      S_GD_SORT: begin phase_d = PH_SORT; step_d = ST_GD; end
      S_GD_ROW:  begin phase_d = PH_ROW;  step_d = ST_GD; end
      S_GD_COL:  begin phase_d = PH_COL;  step_d = ST_GD; end
      default:   begin phase_d = PH_NOP;  step_d = ST_COMP; end
    endcase
    mesh_en_d = (state_d != S_IDLE) && ((state_q == S_IDLE) || !pause);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      round_q   <= '0;
      rounds_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mesh_en_q <= 1'b0;
      phase_q   <= PH_NOP;
      step_q    <= ST_COMP;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      round_q   <= round_d;
      rounds_q  <= rounds_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mesh_en_q <= mesh_en_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
    end
  end

  assign phase     = phase_q;
  assign step      = step_q;
  assign inst_addr = cnt_q;
  assign mesh_en   = mesh_en_q;
  assign busy      = busy_q;
  assign round_idx = round_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mesh_phase_sequencer.sv
// Directed bench for mesh_phase_sequencer with a small mesh (SQRT_N=4, SORT_CYCLES=10).
module tb_mesh_phase_sequencer;
  localparam int SQ = 4;
  localparam int SC = 10;
  localparam int CC = 3;
  localparam int CW = 10;
  localparam int RW = 8;

  localparam int PH [7]  = '{7, 0, 1, 2, 0, 1, 2};
  localparam int ST [7]  = '{2, 0, 0, 0, 1, 1, 1};
  localparam int DUR [7] = '{CC+1, SC+1, SQ+1, SQ+1, SC+1, SQ+1, SQ+1};

  logic          clk = 1'b0;
  logic          rst;
  logic          start, pause, abort;
  logic [RW-1:0] num_rounds;
  logic [2:0]    phase;
  logic [1:0]    step;
  logic [CW-1:0] inst_addr;
  logic          mesh_en, busy, done;
  logic [RW-1:0] round_idx;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;

  mesh_phase_sequencer #(
    .SQRT_N(SQ), .SORT_CYCLES(SC), .COMPUTE_CYCLES(CC),
    .CNT_WIDTH(CW), .ROUND_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_rounds(num_rounds),
    .pause(pause), .abort(abort), .phase(phase), .step(step),
    .inst_addr(inst_addr), .mesh_en(mesh_en), .busy(busy),
    .round_idx(round_idx), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(int ph, int st, int ia, int me, int bz, int dn, int rd);
    return {6'b0, 3'(ph), 2'(st), 10'(ia), 1'(me), 1'(bz), 1'(dn), 8'(rd)};
  endfunction

  function automatic logic [31:0] obs();
    return {6'b0, phase, step, inst_addr, mesh_en, busy, done, round_idx};
  endfunction

  task automatic do_start(input int n);
    start = 1'b1;
    num_rounds = RW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_round(input int rnd);
    for (int s = 0; s < 7; s++) begin
      for (int c = 0; c < DUR[s]; c++) begin
        check_eq($sformatf("seq_r%0d_s%0d_c%0d", rnd, s, c), obs(), pk(PH[s], ST[s], c, 1, 1, 0, rnd));
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int d0;
    int k;
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; num_rounds = '0;
    @(negedge clk);
    check_eq("reset", obs(), pk(7, 2, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(negedge clk);

    // asynchronous reset in round 1, PA_ROW count 2
    do_start(2);
    repeat (63) @(negedge clk);
    check_eq("pre_rst", obs(), pk(1, 0, 2, 1, 1, 0, 1));
    #1 rst = 1'b1;
    #1 check_eq("async_rst", obs(), pk(7, 2, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single round
    d0 = done_pulses;
    do_start(1);
    check_round(0);
    check_eq("r1_done", obs(), pk(7, 2, 0, 0, 0, 1, 0));
    @(negedge clk);
    check_eq("r1_done_clr", obs(), pk(7, 2, 0, 0, 0, 0, 0));
    check_eq("r1_done_once", 32'(done_pulses - d0), 32'd1);

    // three rounds
    do_start(3);
    check_round(0);
    check_round(1);
    check_round(2);
    check_eq("r3_done", obs(), pk(7, 2, 0, 0, 0, 1, 2));
    @(negedge clk);
    check_eq("r3_done_clr", obs(), pk(7, 2, 0, 0, 0, 0, 2));

    // zero rounds behaves as one
    do_start(0);
    check_round(0);
    check_eq("r0_done", obs(), pk(7, 2, 0, 0, 0, 1, 0));
    @(negedge clk);

    // pause for 7 cycles at PA_SORT count 5
    do_start(1);
    repeat (9) @(negedge clk);
    check_eq("pause_pre", obs(), pk(0, 0, 5, 1, 1, 0, 0));
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_eq($sformatf("pause_hold%0d", i), obs(), pk(0, 0, 5, 0, 1, 0, 0));
    end
    pause = 1'b0;
    @(negedge clk);
    check_eq("pause_resume", obs(), pk(0, 0, 6, 1, 1, 0, 0));
    wait_done(17, k);
    check_eq("pause_total", 32'(k), 32'd53);
    @(negedge clk);

    // abort in round 1 GD_ROW count 2 with pause and start also high
    d0 = done_pulses;
    do_start(2);
    repeat (84) @(negedge clk);
    check_eq("abort_pre", obs(), pk(1, 1, 2, 1, 1, 0, 1));
    abort = 1'b1; pause = 1'b1; start = 1'b1; num_rounds = 8'd1;
    @(negedge clk);
    abort = 1'b0; pause = 1'b0; start = 1'b0;
    check_eq("abort_idle", obs(), pk(7, 2, 0, 0, 0, 0, 1));
    @(negedge clk);
    check_eq("abort_idle2", obs(), pk(7, 2, 0, 0, 0, 0, 1));
    check_eq("abort_no_done", 32'(done_pulses - d0), 32'd0);
    do_start(1);
    check_round(0);
    check_eq("abort_restart_done", obs(), pk(7, 2, 0, 0, 0, 1, 0));
    @(negedge clk);

    // start while busy is ignored
    do_start(1);
    start = 1'b1;
    num_rounds = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, k);
    check_eq("ign_total", 32'(k), 32'd46);
    check_eq("ign_done", obs(), pk(7, 2, 0, 0, 0, 1, 0));
    @(negedge clk);
    check_eq("ign_idle", obs(), pk(7, 2, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
